// File: rtl/tmu2_interpdiv18_pkg.sv
// Shared widths, iteration count and FSM state type for the 18-bit interpolation divider.
package tmu2_pkg;

    localparam int COORD_W   = 18;
    localparam int STEP_W    = 17;
    localparam int DIV_ITERS = 17;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_OUT
    } state_t;

    // |d| clamped to the largest value the 17-bit divider can hold.
    function automatic logic [STEP_W-1:0] abs_sat(input logic signed [COORD_W:0] d);
        logic [COORD_W:0] m;
        m = d[COORD_W] ? (~d + 1'b1) : d;
        return (m > {2'b00, {STEP_W{1'b1}}}) ? {STEP_W{1'b1}} : m[STEP_W-1:0];
    endfunction

endpackage

// File: rtl/tmu2_interpdiv18_if.sv
// Segment-in / result-out handshake bundle for tmu2_interpdiv18.
interface tmu2_interpdiv18_if;

    logic                                 pipe_stb_i;
    logic                                 pipe_ack_o;
    logic signed [tmu2_pkg::COORD_W-1:0]  x0;
    logic signed [tmu2_pkg::COORD_W-1:0]  x1;
    logic        [tmu2_pkg::STEP_W-1:0]   steps_i;

    logic                                 pipe_stb_o;
    logic                                 pipe_ack_i;
    logic signed [tmu2_pkg::COORD_W-1:0]  init;
    logic                                 positive;
    logic        [tmu2_pkg::STEP_W-1:0]   q;
    logic        [tmu2_pkg::STEP_W-1:0]   r;
    logic        [tmu2_pkg::STEP_W-1:0]   divisor;

    modport master (
        output pipe_stb_i, x0, x1, steps_i, pipe_ack_i,
        input  pipe_ack_o, pipe_stb_o, init, positive, q, r, divisor
    );

    modport slave (
        input  pipe_stb_i, x0, x1, steps_i, pipe_ack_i,
        output pipe_ack_o, pipe_stb_o, init, positive, q, r, divisor
    );

endinterface

// File: rtl/tmu2_interpdiv18_divcore17.sv
// Sequential 17-bit restoring divider: loads on start, one quotient bit per cycle MSB first,
// done pulses for one cycle after the last of the 17 iterations.
module tmu2_divcore17
    import tmu2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [STEP_W-1:0] dividend,
    input  logic [STEP_W-1:0] dsr_in,
    output logic              done,
    output logic [STEP_W-1:0] quotient,
    output logic [STEP_W-1:0] remainder
);

    logic              run;
    logic [CNT_W-1:0]  cnt;
    logic [STEP_W-1:0] acc;
    logic [STEP_W-1:0] rem;
    logic [STEP_W-1:0] dsr;
    logic [STEP_W:0]   shifted;
    logic [STEP_W-1:0] trial;
    logic              ge;

    // acc starts as the dividend and fills with quotient bits from the right.
    assign shifted   = {rem, acc[STEP_W-1]};
    assign ge        = shifted >= {1'b0, dsr};
    assign trial     = shifted[STEP_W-1:0] - dsr;
    assign quotient  = acc;
    assign remainder = rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            rem  <= '0;
            dsr  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc <= dividend;
                dsr <= dsr_in;
                rem <= '0;
                cnt <= CNT_W'(DIV_ITERS - 1);
                run <= 1'b1;
            end else if (run) begin
                rem <= ge ? trial : shifted[STEP_W-1:0];
                acc <= {acc[STEP_W-2:0], ge};
                if (cnt == '0) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tmu2_interpdiv18.sv
// Segment setup for the texture interpolator: captures x0/steps, forms |x1-x0| with
// saturation and divides it by steps, presenting registered results under stb/ack.
module tmu2_interpdiv18
    import tmu2_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    tmu2_interpdiv18_if.slave    bus,
    output logic                 busy
);

    state_t                  state_q, state_d;
    logic                    xfer;
    logic                    div_done;
    logic                    zero_div;
    logic signed [COORD_W:0] diff;
    logic [STEP_W-1:0]       mag;
    logic [STEP_W-1:0]       quo;
    logic [STEP_W-1:0]       rem;

    assign bus.pipe_ack_o = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign xfer           = bus.pipe_stb_i & (state_q == ST_IDLE);

    assign diff = {bus.x1[COORD_W-1], bus.x1} - {bus.x0[COORD_W-1], bus.x0};
    assign mag  = abs_sat(diff);

    tmu2_divcore17 u_div (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .start     (xfer),
        .dividend  (mag),
        .dsr_in    (bus.steps_i),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.pipe_stb_i) state_d = ST_DIV;
            ST_DIV:  if (div_done)       state_d = ST_OUT;
            ST_OUT:  if (bus.pipe_ack_i) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Results land together with pipe_stb_o and stay frozen until the next transfer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.pipe_stb_o <= 1'b0;
            bus.init       <= '0;
            bus.positive   <= 1'b0;
            bus.divisor    <= '0;
            bus.q          <= '0;
            bus.r          <= '0;
            zero_div       <= 1'b0;
        end else begin
            bus.pipe_stb_o <= (state_d == ST_OUT);
            if (xfer) begin
                bus.init     <= bus.x0;
                bus.positive <= ~diff[COORD_W];
                bus.divisor  <= bus.steps_i;
                zero_div     <= (bus.steps_i == '0);
            end
            if (state_q == ST_DIV && div_done) begin
                bus.q <= zero_div ? '0 : quo;
                bus.r <= zero_div ? '0 : rem;
            end
        end
    end

endmodule
